// File: rtl/code_patch_pkg.sv
// Shared types for the code patch unit.
//   state_e     : transaction FSM states
//   pat_mode_e  : per-entry patch mode (address remap / data replace)
//   pat_entry_t : one patch entry, fields zero-extended to PAT_MAX_W.
//                 Address and payload widths up to PAT_MAX_W are supported.
package code_patch_pkg;

  localparam int PAT_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MATCH = 3'd1,
    FWD   = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic {
    PAT_ADDR = 1'b0,
    PAT_DATA = 1'b1
  } pat_mode_e;

  typedef struct packed {
    logic [PAT_MAX_W-1:0] addr;
    logic [PAT_MAX_W-1:0] mask;
    logic [PAT_MAX_W-1:0] data;
    logic                 pen;
    pat_mode_e            mode;
    logic                 nopg;
    logic                 once;
  } pat_entry_t;

  // Index width that stays legal for a single-entry table.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/code_patch_match.sv
// Masked address compare against all patch entries plus a lowest-index-wins
// priority encoder. Purely combinational.
//   addr_i      : registered transaction address
//   pat_addr_i  : entry match addresses, entry j at [j*ADDR_WIDTH +: ADDR_WIDTH]
//   pat_mask_i  : entry masks, bit=1 takes part in the compare
//   pen_i       : per-entry enable
//   en_i        : global qualifier (patching enabled and transaction is a read)
//   hit_any_o   : at least one entry hits
//   idx_o       : index of the lowest hitting entry (0 when none)
module code_patch_match
  import code_patch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = idx_width(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [NUM_REGS*ADDR_WIDTH-1:0] pat_addr_i,
  input  logic [NUM_REGS*ADDR_WIDTH-1:0] pat_mask_i,
  input  logic [NUM_REGS-1:0]            pen_i,
  input  logic                           en_i,
  output logic                           hit_any_o,
  output logic [IDX_W-1:0]               idx_o
);

  logic [NUM_REGS-1:0] hit;

  always_comb begin
    hit = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      hit[j] = en_i & pen_i[j] &
               (((addr_i ^ pat_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]) &
                 pat_mask_i[j*ADDR_WIDTH +: ADDR_WIDTH]) == '0);
    end
  end

  always_comb begin
    hit_any_o = |hit;
    idx_o     = '0;
    // Scan downwards so the lowest hitting index is the last one written.
    for (int j = NUM_REGS - 1; j >= 0; j--) begin
      if (hit[j]) idx_o = IDX_W'(j);
    end
  end

endmodule

// File: rtl/code_patch_unit.sv
// Handshaked code patch unit between a CPU-side slave port and a ROM-side
// master port. Each read is matched against NUM_REGS masked entries; the
// lowest-index hit either remaps the address, replaces the returned data, or
// answers locally (data mode with no-propagate). Keeps saturating per-entry
// hit counters and pulses pen_clr_o for one-shot entries.
//   clk_i, rst_ni          : clock, async active-low reset
//   si_*                   : slave port (req/gnt, we, addr, rvalid, rdata)
//   mi_*                   : master port (req/gnt, we, addr, rvalid, rdata)
//   cfg_pat_gen_i          : global patch enable
//   ctl_pat_*_i            : entry table, entry j at slice j of each vector
//   pen_clr_o              : one-cycle request to clear an entry's pen bit
//   hit_cnt_clr_i          : synchronous clear of all hit counters
//   hit_cnt_o              : hit counters, entry j at [j*CNT_WIDTH +: CNT_WIDTH]
//   nopg_o                 : marks the completion of a locally answered read
//
// state | meaning
// IDLE  | waiting for a slave request; si_gnt_o follows si_req_i
// MATCH | compare registered address, latch winner, update hit counters
// FWD   | master request held until mi_gnt_i
// RESP  | waiting for mi_rvalid_i, capture read data
// DONE  | one-cycle si_rvalid_o pulse
module code_patch_unit
  import code_patch_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int NUM_REGS            = 16,
  parameter int CNT_WIDTH           = 16,
  parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,

  input  logic                                    si_req_i,
  output logic                                    si_gnt_o,
  input  logic                                    si_we_i,
  input  logic [ADDR_WIDTH-1:0]                   si_addr_i,
  output logic                                    si_rvalid_o,
  output logic [DATA_WIDTH-1:0]                   si_rdata_o,

  output logic                                    mi_req_o,
  input  logic                                    mi_gnt_i,
  output logic                                    mi_we_o,
  output logic [ADDR_WIDTH-1:0]                   mi_addr_o,
  input  logic                                    mi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                   mi_rdata_i,

  input  logic                                    cfg_pat_gen_i,
  input  logic [NUM_REGS*ADDR_WIDTH-1:0]          ctl_pat_addr_i,
  input  logic [NUM_REGS*ADDR_WIDTH-1:0]          ctl_pat_mask_i,
  input  logic [NUM_REGS*SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_i,
  input  logic [NUM_REGS-1:0]                     ctl_pat_pen_i,
  input  logic [NUM_REGS-1:0]                     ctl_pat_mode_i,
  input  logic [NUM_REGS-1:0]                     ctl_pat_nopg_i,
  input  logic [NUM_REGS-1:0]                     ctl_pat_once_i,
  output logic [NUM_REGS-1:0]                     pen_clr_o,

  input  logic                                    hit_cnt_clr_i,
  output logic [NUM_REGS*CNT_WIDTH-1:0]           hit_cnt_o,
  output logic                                    nopg_o
);

  localparam int IDX_W = idx_width(NUM_REGS);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  pat_entry_t            win_q, win_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_REGS];

  pat_entry_t            cfg_ent [NUM_REGS];
  pat_entry_t            win_sel;
  logic                  hit_any;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_addr_mode;
  logic                  win_data_mode;

  always_comb begin
    for (int j = 0; j < NUM_REGS; j++) begin
      cfg_ent[j]      = '0;
      cfg_ent[j].addr = PAT_MAX_W'(ctl_pat_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]);
      cfg_ent[j].mask = PAT_MAX_W'(ctl_pat_mask_i[j*ADDR_WIDTH +: ADDR_WIDTH]);
      cfg_ent[j].data = PAT_MAX_W'(ctl_pat_data_i[j*SUB_REGS_DATA_WIDTH +: SUB_REGS_DATA_WIDTH]);
      cfg_ent[j].pen  = ctl_pat_pen_i[j];
      cfg_ent[j].mode = pat_mode_e'(ctl_pat_mode_i[j]);
      cfg_ent[j].nopg = ctl_pat_nopg_i[j];
      cfg_ent[j].once = ctl_pat_once_i[j];
    end
  end

  code_patch_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_match (
    .addr_i     (addr_q),
    .pat_addr_i (ctl_pat_addr_i),
    .pat_mask_i (ctl_pat_mask_i),
    .pen_i      (ctl_pat_pen_i),
    .en_i       (cfg_pat_gen_i & ~we_q),
    .hit_any_o  (hit_any),
    .idx_o      (win_idx)
  );

  assign win_sel = cfg_ent[win_idx];

  // win_q.pen doubles as "this transaction has a winner": it is only ever
  // loaded from a hitting entry, whose pen bit is necessarily set.
  assign win_addr_mode = win_q.pen & (win_q.mode == PAT_ADDR);
  assign win_data_mode = win_q.pen & (win_q.mode == PAT_DATA);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    win_d     = win_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    si_gnt_o  = 1'b0;
    pen_clr_o = '0;

    case (state_q)
      IDLE: begin
        si_gnt_o = si_req_i;
        if (si_req_i) begin
          addr_d  = si_addr_i;
          we_d    = si_we_i;
          state_d = MATCH;
        end
      end

      MATCH: begin
        win_d = '0;
        if (hit_any) begin
          win_d = win_sel;
          if (cnt_q[win_idx] != '1) cnt_d[win_idx] = cnt_q[win_idx] + CNT_WIDTH'(1);
          if (win_sel.once) pen_clr_o[win_idx] = 1'b1;
        end
        if (hit_any && win_sel.mode == PAT_DATA && win_sel.nopg) begin
          rdata_d = win_sel.data[DATA_WIDTH-1:0];
          state_d = DONE;
        end else begin
          state_d = FWD;
        end
      end

      FWD: begin
        if (mi_gnt_i) state_d = RESP;
      end

      RESP: begin
        if (mi_rvalid_i) begin
          rdata_d = win_data_mode ? win_q.data[DATA_WIDTH-1:0] : mi_rdata_i;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear has priority over any increment made in the same cycle.
    if (hit_cnt_clr_i) begin
      for (int j = 0; j < NUM_REGS; j++) cnt_d[j] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      win_q   <= '0;
      rdata_q <= '0;
      for (int j = 0; j < NUM_REGS; j++) cnt_q[j] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      win_q   <= win_d;
      rdata_q <= rdata_d;
      for (int j = 0; j < NUM_REGS; j++) cnt_q[j] <= cnt_d[j];
    end
  end

  // Master port is driven purely from registered state, so it stays stable
  // from FWD entry until the grant regardless of config changes.
  assign mi_req_o    = (state_q == FWD);
  assign mi_we_o     = (state_q == FWD) & we_q;
  assign mi_addr_o   = (state_q != FWD) ? '0 :
                       win_addr_mode ? win_q.data[ADDR_WIDTH-1:0] : addr_q;

  assign si_rvalid_o = (state_q == DONE);
  assign si_rdata_o  = (state_q == DONE && !we_q) ? rdata_q : '0;
  assign nopg_o      = (state_q == DONE) & win_data_mode & win_q.nopg;

  always_comb begin
    hit_cnt_o = '0;
    for (int j = 0; j < NUM_REGS; j++) hit_cnt_o[j*CNT_WIDTH +: CNT_WIDTH] = cnt_q[j];
  end

  logic unused_win;
  assign unused_win = ^{win_q.addr, win_q.mask, win_q.once, win_q.data};

endmodule

// File: tb/tb_code_patch_unit.sv
module tb_code_patch_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int CW = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              si_req_i, si_we_i;
  logic [AW-1:0]     si_addr_i;
  logic              si_gnt_o, si_rvalid_o;
  logic [DW-1:0]     si_rdata_o;
  logic              mi_req_o, mi_gnt_i, mi_we_o, mi_rvalid_i;
  logic [AW-1:0]     mi_addr_o;
  logic [DW-1:0]     mi_rdata_i;
  logic              cfg_pat_gen_i;
  logic [NR*AW-1:0]  ctl_pat_addr_i, ctl_pat_mask_i, ctl_pat_data_i;
  logic [NR-1:0]     ctl_pat_pen_i, ctl_pat_mode_i, ctl_pat_nopg_i, ctl_pat_once_i;
  logic [NR-1:0]     pen_clr_o;
  logic              hit_cnt_clr_i;
  logic [NR*CW-1:0]  hit_cnt_o;
  logic              nopg_o;

  // Entry table as software sees it
  logic [31:0] m_addr [NR];
  logic [31:0] m_mask [NR];
  logic [31:0] m_data [NR];
  logic        m_pen  [NR];
  logic        m_mode [NR];
  logic        m_nopg [NR];
  logic        m_once [NR];
  logic [CW-1:0] cnt_m [NR];

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 0;

  logic [31:0] last_maddr, last_rdata;
  logic [NR-1:0] last_pen_clr;

  always #5 clk_i = ~clk_i;

  always_comb begin
    ctl_pat_addr_i = '0; ctl_pat_mask_i = '0; ctl_pat_data_i = '0;
    ctl_pat_pen_i = '0; ctl_pat_mode_i = '0; ctl_pat_nopg_i = '0; ctl_pat_once_i = '0;
    for (int j = 0; j < NR; j++) begin
      ctl_pat_addr_i[j*AW +: AW] = m_addr[j];
      ctl_pat_mask_i[j*AW +: AW] = m_mask[j];
      ctl_pat_data_i[j*AW +: AW] = m_data[j];
      ctl_pat_pen_i[j]  = m_pen[j];
      ctl_pat_mode_i[j] = m_mode[j];
      ctl_pat_nopg_i[j] = m_nopg[j];
      ctl_pat_once_i[j] = m_once[j];
    end
  end

  code_patch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .CNT_WIDTH(CW), .SUB_REGS_DATA_WIDTH(32)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .si_req_i(si_req_i), .si_gnt_o(si_gnt_o), .si_we_i(si_we_i), .si_addr_i(si_addr_i),
    .si_rvalid_o(si_rvalid_o), .si_rdata_o(si_rdata_o),
    .mi_req_o(mi_req_o), .mi_gnt_i(mi_gnt_i), .mi_we_o(mi_we_o), .mi_addr_o(mi_addr_o),
    .mi_rvalid_i(mi_rvalid_i), .mi_rdata_i(mi_rdata_i),
    .cfg_pat_gen_i(cfg_pat_gen_i),
    .ctl_pat_addr_i(ctl_pat_addr_i), .ctl_pat_mask_i(ctl_pat_mask_i),
    .ctl_pat_data_i(ctl_pat_data_i), .ctl_pat_pen_i(ctl_pat_pen_i),
    .ctl_pat_mode_i(ctl_pat_mode_i), .ctl_pat_nopg_i(ctl_pat_nopg_i),
    .ctl_pat_once_i(ctl_pat_once_i), .pen_clr_o(pen_clr_o),
    .hit_cnt_clr_i(hit_cnt_clr_i), .hit_cnt_o(hit_cnt_o), .nopg_o(nopg_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Lowest enabled entry whose compared bits equal the address; reads only.
  function automatic int find_winner(input logic [31:0] a, input logic we);
    if (we || !cfg_pat_gen_i) return -1;
    for (int j = 0; j < NR; j++)
      if (m_pen[j] && (((a ^ m_addr[j]) & m_mask[j]) == 32'h0)) return j;
    return -1;
  endfunction

  function automatic logic [NR*CW-1:0] cnt_packed();
    logic [NR*CW-1:0] v;
    v = '0;
    for (int j = 0; j < NR; j++) v[j*CW +: CW] = cnt_m[j];
    return v;
  endfunction

  // State-only outputs checked every cycle against the model
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk_i);
      #2;
      if (!si_rvalid_o) begin
        chk("idle_rdata_zero", si_rdata_o, 0);
        chk("idle_nopg_zero", nopg_o, 0);
      end
      chk("hit_cnt", hit_cnt_o, cnt_packed());
    end
  end

  task automatic run_txn(input string nm, input logic [31:0] addr, input logic we,
                         input int gnt_wait, input logic [31:0] rom,
                         input bit clr, input bit perturb);
    int w;
    bit loc;
    logic [31:0] ea, ed;
    logic [NR-1:0] epc;
    w   = find_winner(addr, we);
    loc = (w >= 0) && m_mode[w] && m_nopg[w];
    ea  = (w >= 0 && !m_mode[w]) ? m_data[w] : addr;
    ed  = we ? 32'h0 : ((w >= 0 && m_mode[w]) ? m_data[w] : rom);
    epc = (w >= 0 && m_once[w]) ? NR'(32'd1 << w) : '0;

    @(negedge clk_i);                           // cycle 0: accept
    si_req_i = 1; si_we_i = we; si_addr_i = addr;
    #1 chk({nm, "/gnt"}, si_gnt_o, 1);

    @(negedge clk_i);                           // cycle 1: match (req kept high)
    hit_cnt_clr_i = clr;
    #1;
    chk({nm, "/gnt_busy"}, si_gnt_o, 0);
    chk({nm, "/pen_clr"}, pen_clr_o, epc);
    chk({nm, "/mreq_match"}, mi_req_o, 0);
    last_pen_clr = pen_clr_o;

    @(negedge clk_i);                           // cycle 2
    si_req_i = 0; si_we_i = 0; si_addr_i = '0; hit_cnt_clr_i = 0;
    if (clr) for (int j = 0; j < NR; j++) cnt_m[j] = '0;
    else if (w >= 0 && cnt_m[w] != '1) cnt_m[w] = cnt_m[w] + 1'b1;
    #1;
    if (loc) begin
      chk({nm, "/rvalid_local"}, si_rvalid_o, 1);
      chk({nm, "/rdata_local"}, si_rdata_o, ed);
      chk({nm, "/nopg"}, nopg_o, 1);
      chk({nm, "/mreq_local"}, mi_req_o, 0);
      last_rdata = si_rdata_o;
    end else begin
      for (int k = 0; k <= gnt_wait; k++) begin
        if (k > 0) begin
          @(negedge clk_i);
          mi_rvalid_i = 0; mi_rdata_i = '0;
          #1;
        end
        chk({nm, "/mreq"}, mi_req_o, 1);
        chk({nm, "/maddr"}, mi_addr_o, ea);
        chk({nm, "/mwe"}, mi_we_o, we);
        chk({nm, "/rvalid_fwd"}, si_rvalid_o, 0);
        if (k == 0) last_maddr = mi_addr_o;
        if (perturb && k == 0 && w >= 0) m_data[w] = m_data[w] ^ 32'hFFFF_0000;
        if (k < gnt_wait) begin
          mi_rvalid_i = 1; mi_rdata_i = 32'hBAD0_BAD0;  // must be ignored here
        end else begin
          mi_gnt_i = 1;
        end
      end
      @(negedge clk_i);                         // RESP
      mi_gnt_i = 0;
      #1;
      chk({nm, "/mreq_resp"}, mi_req_o, 0);
      chk({nm, "/rvalid_resp"}, si_rvalid_o, 0);
      mi_rvalid_i = 1; mi_rdata_i = rom;
      @(negedge clk_i);                         // DONE
      mi_rvalid_i = 0; mi_rdata_i = '0;
      #1;
      chk({nm, "/rvalid"}, si_rvalid_o, 1);
      chk({nm, "/rdata"}, si_rdata_o, ed);
      chk({nm, "/nopg_fwd"}, nopg_o, 0);
      last_rdata = si_rdata_o;
      if (perturb && w >= 0) m_data[w] = m_data[w] ^ 32'hFFFF_0000;
    end
    @(negedge clk_i);
    #1 chk({nm, "/rvalid_pulse"}, si_rvalid_o, 0);
  endtask

  initial begin
    rst_ni = 0; si_req_i = 0; si_we_i = 0; si_addr_i = '0;
    mi_gnt_i = 0; mi_rvalid_i = 0; mi_rdata_i = '0;
    cfg_pat_gen_i = 1; hit_cnt_clr_i = 0;
    for (int j = 0; j < NR; j++) begin
      m_addr[j] = '0; m_mask[j] = '1; m_data[j] = '0;
      m_pen[j] = 0; m_mode[j] = 0; m_nopg[j] = 0; m_once[j] = 0; cnt_m[j] = '0;
    end
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_gnt", si_gnt_o, 0);
    chk("rst_rvalid", si_rvalid_o, 0);
    chk("rst_rdata", si_rdata_o, 0);
    chk("rst_mreq", mi_req_o, 0);
    chk("rst_mwe", mi_we_o, 0);
    chk("rst_maddr", mi_addr_o, 0);
    chk("rst_penclr", pen_clr_o, 0);
    chk("rst_cnt", hit_cnt_o, 0);
    chk("rst_nopg", nopg_o, 0);
    @(negedge clk_i);
    rst_ni = 1;
    mon_en = 1;

    // entry table
    m_addr[3] = 32'h1000; m_data[3] = 32'h8000; m_pen[3] = 1;
    m_addr[2] = 32'h2004; m_data[2] = 32'h9000; m_pen[2] = 1;
    m_addr[5] = 32'h2000; m_mask[5] = 32'hFFFF_FF00; m_data[5] = 32'hA000; m_pen[5] = 1;
    m_addr[0] = 32'h3000; m_data[0] = 32'hDEAD_BEEF; m_mode[0] = 1; m_nopg[0] = 1; m_pen[0] = 1;
    m_addr[1] = 32'h4000; m_data[1] = 32'h4400; m_once[1] = 1; m_pen[1] = 1;
    m_addr[6] = 32'h5000; m_data[6] = 32'hCAFE_F00D; m_mode[6] = 1; m_pen[6] = 1;
    m_addr[4] = 32'h6000; m_data[4] = 32'h44; m_mode[4] = 1; m_nopg[4] = 1; m_pen[4] = 1;

    run_txn("remap", 32'h1000, 0, 0, 32'h1234_5678, 0, 0);
    chk("pin_remap_addr", last_maddr, 32'h8000);
    chk("pin_remap_data", last_rdata, 32'h1234_5678);
    chk("pin_remap_cnt3", hit_cnt_o[3*CW +: CW], 1);

    run_txn("prio", 32'h2004, 0, 0, 32'h0000_2004, 0, 0);
    chk("pin_prio_addr", last_maddr, 32'h9000);
    chk("pin_prio_cnt2", hit_cnt_o[2*CW +: CW], 1);
    chk("pin_prio_cnt5", hit_cnt_o[5*CW +: CW], 0);

    run_txn("local", 32'h3000, 0, 0, 32'h0, 0, 0);
    chk("pin_local_data", last_rdata, 32'hDEAD_BEEF);

    run_txn("once", 32'h4000, 0, 0, 32'h5555_0000, 0, 0);
    chk("pin_once_clr", last_pen_clr, 8'h02);
    m_pen[1] = 0;
    run_txn("once_again", 32'h4000, 0, 1, 32'h5555_0001, 0, 0);
    chk("pin_once_pass", last_maddr, 32'h4000);
    chk("pin_once_noclr", last_pen_clr, 8'h00);

    run_txn("data_repl", 32'h5000, 0, 2, 32'h1111_1111, 0, 1);
    chk("pin_repl_data", last_rdata, 32'hCAFE_F00D);

    run_txn("write", 32'h1000, 1, 0, 32'h7777_7777, 0, 0);
    chk("pin_write_addr", last_maddr, 32'h1000);

    cfg_pat_gen_i = 0;
    run_txn("gen_off", 32'h1000, 0, 0, 32'h2222_3333, 0, 0);
    chk("pin_genoff_addr", last_maddr, 32'h1000);
    cfg_pat_gen_i = 1;

    for (int i = 0; i < 4; i++) run_txn("sat", 32'h6000, 0, 0, 32'h0, 0, 0);
    chk("pin_sat_cnt4", hit_cnt_o[4*CW +: CW], 3);
    run_txn("clr_win", 32'h6000, 0, 0, 32'h0, 1, 0);
    chk("pin_clr_all", hit_cnt_o, 0);
    run_txn("after_clr", 32'h1000, 0, 0, 32'hABCD_0123, 0, 0);
    chk("pin_after_clr_cnt3", hit_cnt_o[3*CW +: CW], 1);

    // reset while waiting for master data
    @(negedge clk_i);
    si_req_i = 1; si_addr_i = 32'h7000;
    @(negedge clk_i);
    si_req_i = 0; si_addr_i = '0;
    @(negedge clk_i);
    #1 chk("rst_mid/mreq", mi_req_o, 1);
    mi_gnt_i = 1;
    @(negedge clk_i);
    mi_gnt_i = 0;
    #1;
    rst_ni = 0;
    for (int j = 0; j < NR; j++) cnt_m[j] = '0;
    #1;
    chk("rst_mid/rvalid", si_rvalid_o, 0);
    chk("rst_mid/mreq_off", mi_req_o, 0);
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
    mi_rvalid_i = 1; mi_rdata_i = 32'h0000_0077;
    @(negedge clk_i);
    mi_rvalid_i = 0; mi_rdata_i = '0;
    #1 chk("rst_mid/no_rvalid", si_rvalid_o, 0);
    @(negedge clk_i);
    #1 chk("rst_mid/no_rvalid2", si_rvalid_o, 0);
    si_req_i = 1;
    #1 chk("rst_mid/idle_gnt", si_gnt_o, 1);
    si_req_i = 0;
    @(negedge clk_i);
    #1 chk("rst_mid/stay_idle", mi_req_o, 0);

    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
